ycbcr2rgb_pipe: RTL

YCBCR2RGB_PIPE -- requirements
Module: ycbcr2rgb_pipe

---
 rtl/ycbcr2rgb_pipe_if.sv | 20 ++
 rtl/ycbcr2rgb_pipe.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ycbcr2rgb_pipe_if.sv
// Pixel stream bundle for ycbcr2rgb_pipe: YCbCr + mode + sideband in, clamped RGB out.
interface ycbcr2rgb_pipe_if #(
  parameter int OUT_W = 10,
  parameter int SB_W  = 2
);
  logic [7:0]       iY, iCb, iCr;
  logic [1:0]       iMODE;
  logic [SB_W-1:0]  iSB;
  logic             iVALID;
  logic             oREADY;
  logic [OUT_W-1:0] oRed, oGreen, oBlue;
  logic [SB_W-1:0]  oSB;
  logic             oVALID;
  logic             iREADY;

  modport slave  (input  iY, iCb, iCr, iMODE, iSB, iVALID, iREADY,
                  output oREADY, oRed, oGreen, oBlue, oSB, oVALID);
  modport master (output iY, iCb, iCr, iMODE, iSB, iVALID, iREADY,
                  input  oREADY, oRed, oGreen, oBlue, oSB, oVALID);
endinterface

// File: rtl/ycbcr2rgb_pipe.sv
// 3-stage YCbCr->RGB converter (BT.601/BT.709/bypass) with stall-able valid/ready
// pipeline and a saturating clip counter. One lane instance per output channel.
module ycbcr2rgb_lane #(
  parameter int LANE  = 0,
  parameter int OUT_W = 10
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             en1, en2, en3,
  input  logic             sel709,
  input  logic [1:0]       mode1,
  input  logic [7:0]       y, cb, cr,
  output logic [OUT_W-1:0] pixOut,
  output logic             clipOut
);
  localparam int SUM_W = 22;
  localparam int SH    = 17 - OUT_W;
  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((1 << OUT_W) - 1);

  logic signed [SUM_W-1:0] cY, cCb, cCr, off, yS, cbS, crS;
  logic signed [SUM_W-1:0] pY, pCb, pCr, sum2, shifted;
  logic [7:0] bypIn, byp1;

  assign yS  = $signed({14'd0, y});
  assign cbS = $signed({14'd0, cb});
  assign crS = $signed({14'd0, cr});

  always_comb begin
    cY    = 22'sd596;
    cCb   = '0;
    cCr   = '0;
    bypIn = y;
    case (LANE)
      0: cCr = sel709 ? 22'sd918 : 22'sd817;
      1: begin
        cCb   = sel709 ? -22'sd109 : -22'sd200;
        cCr   = sel709 ? -22'sd273 : -22'sd416;
        bypIn = cb;
      end
      default: begin
        cCb   = sel709 ? 22'sd1081 : 22'sd1033;
        bypIn = cr;
      end
    endcase
  end

  always_comb begin
    case (LANE)
      0:       off = mode1[0] ? -22'sd127040 : -22'sd114131;
      1:       off = mode1[0] ?  22'sd39360  :  22'sd69370;
      default: off = mode1[0] ? -22'sd147904 : -22'sd141787;
    endcase
  end

  // Bypass pre-scales by 2^9 so the common shift leaves v << (OUT_W-8), never clamped.
  assign shifted = sum2 >>> SH;

  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      pY <= '0; pCb <= '0; pCr <= '0; byp1 <= '0;
      sum2 <= '0; pixOut <= '0; clipOut <= 1'b0;
    end else begin
      if (en1) begin
        pY   <= cY * yS;
        pCb  <= cCb * cbS;
        pCr  <= cCr * crS;
        byp1 <= bypIn;
      end
      if (en2) sum2 <= mode1[1] ? $signed({5'd0, byp1, 9'd0}) : pY + pCb + pCr + off;
      if (en3) begin
        if (shifted[SUM_W-1]) begin
          pixOut <= '0; clipOut <= 1'b1;
        end else if (shifted > MAXV) begin
          pixOut <= '1; clipOut <= 1'b1;
        end else begin
          pixOut <= shifted[OUT_W-1:0]; clipOut <= 1'b0;
        end
      end
    end
endmodule

module ycbcr2rgb_pipe #(
  parameter int OUT_W = 10,
  parameter int SB_W  = 2,
  parameter int CNT_W = 24
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  ycbcr2rgb_pipe_if.slave    pix,
  input  logic               iCLR_CNT,
  output logic [CNT_W-1:0]   oCLIP_CNT
);
  localparam int STAGES = 3;

  logic [STAGES:1]       vldPipe, ld, en;
  logic [1:0]            mode1;
  logic [SB_W-1:0]       sb1, sb2, sb3;
  logic [2:0][OUT_W-1:0] rgb;
  logic [2:0]            clip;
  logic                  xfer;

  // Ready ripples back from the output: a stage loads if empty or draining.
  assign ld[3] = ~vldPipe[3] | pix.iREADY;
  assign ld[2] = ~vldPipe[2] | ld[3];
  assign ld[1] = ~vldPipe[1] | ld[2];
  assign en[1] = ld[1] & pix.iVALID;
  assign en[2] = ld[2] & vldPipe[1];
  assign en[3] = ld[3] & vldPipe[2];
  assign xfer  = vldPipe[3] & pix.iREADY;

  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      vldPipe <= '0; mode1 <= '0; sb1 <= '0; sb2 <= '0; sb3 <= '0;
    end else begin
      if (ld[1]) vldPipe[1] <= pix.iVALID;
      if (ld[2]) vldPipe[2] <= vldPipe[1];
      if (ld[3]) vldPipe[3] <= vldPipe[2];
      if (en[1]) begin mode1 <= pix.iMODE; sb1 <= pix.iSB; end
      if (en[2]) sb2 <= sb1;
      if (en[3]) sb3 <= sb2;
    end

  for (genvar g = 0; g < 3; g++) begin : gLane
    ycbcr2rgb_lane #(.LANE(g), .OUT_W(OUT_W)) uLane (
      .iCLK    (iCLK),
      .iRST_N  (iRST_N),
      .en1     (en[1]),
      .en2     (en[2]),
      .en3     (en[3]),
      .sel709  (pix.iMODE[0]),
      .mode1   (mode1),
      .y       (pix.iY),
      .cb      (pix.iCb),
      .cr      (pix.iCr),
      .pixOut  (rgb[g]),
      .clipOut (clip[g])
    );
  end

  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N)                                  oCLIP_CNT <= '0;
    else if (iCLR_CNT)                            oCLIP_CNT <= '0;
    else if (xfer && (|clip) && !(&oCLIP_CNT))    oCLIP_CNT <= oCLIP_CNT + 1'b1;

  assign pix.oREADY = ld[1];
  assign pix.oVALID = vldPipe[3];
  assign pix.oRed   = rgb[0];
  assign pix.oGreen = rgb[1];
  assign pix.oBlue  = rgb[2];
  assign pix.oSB    = sb3;
endmodule
